// File: rtl/color_recipe_sequencer.sv
// Colour recipe sequencer: looks up per-colorant round counts and walks the carriage R->Y->B,
// dispensing at each station, then homes. Optional CUSTOM_RECIPE_EN adds a user recipe on color_id 15.
module color_recipe_sequencer #(
  parameter int DEPTH      = 6,
  parameter int MOVE_TICKS = 2
) (
  input  logic       clk_cnt,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] color_id,
`ifdef CUSTOM_RECIPE_EN
  input  logic [3:0] cust_r,
  input  logic [3:0] cust_y,
  input  logic [3:0] cust_b,
`endif
  output logic       en_r,
  output logic       en_y,
  output logic       en_b,
  output logic       carriage_en,
  output logic       carriage_dir,
  output logic [1:0] station,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  // Phase counter must hold 15 rounds x DEPTH and the longer home move.
  localparam int TW = $clog2(15 * DEPTH + 2 * MOVE_TICKS + 1);
  localparam logic [TW-1:0] DEPTH_W   = TW'(DEPTH);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] HOME_LAST = TW'(2 * MOVE_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DROP = 3'd2,
    S_MOVE = 3'd3,
    S_HOME = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt_r, r_cnt_y, r_cnt_b;
  logic [TW-1:0]   r_tick;
  logic [1:0]      r_station;
  logic            r_en_r, r_en_y, r_en_b;
  logic            r_car_en, r_car_dir;
  logic            r_busy, r_done, r_err;

  logic            w_rec_valid;
  logic [3:0]      w_rec_r, w_rec_y, w_rec_b;
  logic [1:0]      w_next_st;
  logic [3:0]      w_next_cnt;

  always_comb begin
    w_rec_valid = 1'b1;
    w_rec_r     = 4'd0;
    w_rec_y     = 4'd0;
    w_rec_b     = 4'd0;
    case (color_id)
      4'd0: {w_rec_r, w_rec_y, w_rec_b} = {4'd2, 4'd4, 4'd7};
      4'd1: {w_rec_r, w_rec_y, w_rec_b} = {4'd5, 4'd0, 4'd0};
      4'd2: {w_rec_r, w_rec_y, w_rec_b} = {4'd0, 4'd5, 4'd0};
      4'd3: {w_rec_r, w_rec_y, w_rec_b} = {4'd0, 4'd0, 4'd5};
      4'd4: {w_rec_r, w_rec_y, w_rec_b} = {4'd3, 4'd3, 4'd0};
      4'd5: {w_rec_r, w_rec_y, w_rec_b} = {4'd0, 4'd3, 4'd3};
      4'd6: {w_rec_r, w_rec_y, w_rec_b} = {4'd3, 4'd0, 4'd3};
      4'd7: {w_rec_r, w_rec_y, w_rec_b} = {4'd2, 4'd2, 4'd2};
`ifdef CUSTOM_RECIPE_EN
      4'd15: begin
        {w_rec_r, w_rec_y, w_rec_b} = {cust_r, cust_y, cust_b};
        w_rec_valid = |{cust_r, cust_y, cust_b};
      end
`endif
      default: w_rec_valid = 1'b0;
    endcase
  end

  // Station the carriage arrives at when the current hop finishes, and its count.
  always_comb begin
    w_next_st = r_station + 2'd1;
    case (w_next_st)
      2'd1:    w_next_cnt = r_cnt_y;
      2'd2:    w_next_cnt = r_cnt_b;
      default: w_next_cnt = r_cnt_r;
    endcase
  end

  function automatic logic [TW-1:0] drop_last(input logic [3:0] c);
    return (TW'(c) * DEPTH_W) - TW'(1);
  endfunction

  // Outputs are registered and always set together with the state they belong to.
  always_ff @(posedge clk_cnt or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt_r   <= 4'd0;
      r_cnt_y   <= 4'd0;
      r_cnt_b   <= 4'd0;
      r_tick    <= '0;
      r_station <= 2'd0;
      r_en_r    <= 1'b0;
      r_en_y    <= 1'b0;
      r_en_b    <= 1'b0;
      r_car_en  <= 1'b0;
      r_car_dir <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            if (w_rec_valid) begin
              r_cnt_r   <= w_rec_r;
              r_cnt_y   <= w_rec_y;
              r_cnt_b   <= w_rec_b;
              r_station <= 2'd0;
              r_busy    <= 1'b1;
              r_state   <= S_LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (r_cnt_r != 4'd0) begin
            r_state <= S_DROP;
            r_en_r  <= 1'b1;
            r_tick  <= drop_last(r_cnt_r);
          end else begin
            r_state   <= S_MOVE;
            r_car_en  <= 1'b1;
            r_car_dir <= 1'b0;
            r_tick    <= MOVE_LAST;
          end
        end
        S_DROP: begin
          if (r_tick == '0) begin
            r_en_r   <= 1'b0;
            r_en_y   <= 1'b0;
            r_en_b   <= 1'b0;
            r_car_en <= 1'b1;
            if (r_station == 2'd2) begin
              r_state   <= S_HOME;
              r_car_dir <= 1'b1;
              r_tick    <= HOME_LAST;
            end else begin
              r_state   <= S_MOVE;
              r_car_dir <= 1'b0;
              r_tick    <= MOVE_LAST;
            end
          end else begin
            r_tick <= r_tick - TW'(1);
          end
        end
        S_MOVE: begin
          if (r_tick == '0) begin
            r_station <= w_next_st;
            if (w_next_cnt != 4'd0) begin
              r_state  <= S_DROP;
              r_car_en <= 1'b0;
              r_en_y   <= (w_next_st == 2'd1);
              r_en_b   <= (w_next_st == 2'd2);
              r_tick   <= drop_last(w_next_cnt);
            end else if (w_next_st == 2'd2) begin
              r_state   <= S_HOME;
              r_car_dir <= 1'b1;
              r_tick    <= HOME_LAST;
            end else begin
              r_tick <= MOVE_LAST;
            end
          end else begin
            r_tick <= r_tick - TW'(1);
          end
        end
        S_HOME: begin
          if (r_tick == '0) begin
            r_car_en  <= 1'b0;
            r_car_dir <= 1'b0;
            r_station <= 2'd0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tick <= r_tick - TW'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign en_r         = r_en_r;
  assign en_y         = r_en_y;
  assign en_b         = r_en_b;
  assign carriage_en  = r_car_en;
  assign carriage_dir = r_car_dir;
  assign station      = r_station;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_color_recipe_sequencer.sv
// Directed, table-driven bench for color_recipe_sequencer (DEPTH=6, MOVE_TICKS=2), plus
// hand-written sequences for mid-run reset and a held request.
module tb_color_recipe_sequencer;

  logic       clk_cnt;
  logic       rst;
  logic       req;
  logic [3:0] color_id;
  logic [3:0] cust_r, cust_y, cust_b;
  logic       en_r, en_y, en_b, carriage_en, carriage_dir;
  logic [1:0] station;
  logic       busy, done, err;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  color_recipe_sequencer #(.DEPTH(6), .MOVE_TICKS(2)) dut (
    .clk_cnt      (clk_cnt),
    .rst          (rst),
    .req          (req),
    .color_id     (color_id),
`ifdef CUSTOM_RECIPE_EN
    .cust_r       (cust_r),
    .cust_y       (cust_y),
    .cust_b       (cust_b),
`endif
    .en_r         (en_r),
    .en_y         (en_y),
    .en_b         (en_b),
    .carriage_en  (carriage_en),
    .carriage_dir (carriage_dir),
    .station      (station),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk_cnt = 1'b0;
  always #5 clk_cnt = ~clk_cnt;

  typedef struct {
    logic [3:0] id;
    logic [3:0] cr, cy, cb;
    int         busy, r, y, b, done, err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] id, input logic [3:0] cr, input logic [3:0] cy,
                              input logic [3:0] cb, input int bz, input int r, input int y,
                              input int b, input int dn, input int er);
    vec_t v;
    v.id = id; v.cr = cr; v.cy = cy; v.cb = cb;
    v.busy = bz; v.r = r; v.y = y; v.b = b; v.done = dn; v.err = er;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({en_r, en_y, en_b, carriage_en, carriage_dir, station, busy, done, err});
  endfunction

  // Driver: one-cycle request, then a fixed 100-cycle observation window.
  task automatic run_txn(input vec_t v, input string tag);
    int n_busy = 0, n_r = 0, n_y = 0, n_b = 0, n_fwd = 0, n_home = 0;
    int n_done = 0, n_err = 0, n_ovl = 0, n_ord = 0, phase = 0;
    int exp_move;
    @(negedge clk_cnt);
    color_id = v.id;
    cust_r = v.cr; cust_y = v.cy; cust_b = v.cb;
    req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_cnt);
      req = 1'b0;
      n_busy += int'(busy);
      n_r    += int'(en_r);
      n_y    += int'(en_y);
      n_b    += int'(en_b);
      n_fwd  += int'(carriage_en && !carriage_dir);
      n_home += int'(carriage_en && carriage_dir);
      n_done += int'(done);
      n_err  += int'(err);
      if ((int'(en_r) + int'(en_y) + int'(en_b) + int'(carriage_en)) > 1) n_ovl++;
      if (en_r && phase > 0) n_ord++;
      if (en_y) begin
        if (phase > 1) n_ord++;
        if (phase < 1) phase = 1;
      end
      if (en_b) phase = 2;
    end
    exp_move = (v.done != 0) ? 4 : 0;
    check({tag, ".busy"}, n_busy, v.busy);
    check({tag, ".en_r"}, n_r, v.r);
    check({tag, ".en_y"}, n_y, v.y);
    check({tag, ".en_b"}, n_b, v.b);
    check({tag, ".fwd"}, n_fwd, exp_move);
    check({tag, ".home"}, n_home, exp_move);
    check({tag, ".done"}, n_done, v.done);
    check({tag, ".err"}, n_err, v.err);
    check({tag, ".overlap"}, n_ovl, 0);
    check({tag, ".order"}, n_ord, 0);
    check({tag, ".station_end"}, int'(station), 0);
  endtask

  // Mid-sequence reset during the yellow drop of recipe 7, then a clean recipe 3 run.
  task automatic rst_mid_seq();
    int found = 0, n_done = 0;
    @(negedge clk_cnt);
    color_id = 4'd7;
    req = 1'b1;
    for (int i = 0; i < 60 && found == 0; i++) begin
      @(negedge clk_cnt);
      req = 1'b0;
      if (en_y) found = 1;
      n_done += int'(done);
    end
    check("rst_mid.reach_y", found, 1);
    repeat (3) @(negedge clk_cnt);
    #2 rst = 1'b1;
    #1 check("rst_mid.async_outs", all_outs(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_cnt);
      n_done += int'(done);
    end
    check("rst_mid.no_done", n_done, 0);
    rst = 1'b0;
    run_txn(mk(4'd3, 4'd0, 4'd0, 4'd0, 40, 0, 0, 30, 1, 0), "after_rst.id3");
  endtask

  // Request held through a recipe 2 run; a mid-run toggle and id change must be ignored.
  task automatic held_req_seq();
    int seg = 0, run1 = 0, gap = 0, run2 = 0, n_done = 0, n_y = 0, n_r = 0;
    @(negedge clk_cnt);
    color_id = 4'd2;
    req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_cnt);
      if (seg == 0) begin
        if (busy) run1++;
        else begin seg = 1; gap++; end
      end else if (seg == 1) begin
        if (busy) begin seg = 2; run2++; end
        else gap++;
      end else if (seg == 2) begin
        if (busy) run2++;
        else seg = 3;
      end
      n_done += int'(done);
      n_y    += int'(en_y);
      n_r    += int'(en_r);
      if (i == 10) begin req = 1'b0; color_id = 4'd9; end
      if (i == 13) begin req = 1'b1; color_id = 4'd2; end
      if (i == 50) req = 1'b0;
    end
    check("held.run1", run1, 40);
    check("held.gap", gap, 1);
    check("held.run2", run2, 40);
    check("held.done", n_done, 2);
    check("held.en_y", n_y, 60);
    check("held.en_r", n_r, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    color_id = 4'd0;
    cust_r = 4'd0; cust_y = 4'd0; cust_b = 4'd0;

    //                id    cr    cy    cb   busy  r   y   b  done err
    tbl.push_back(mk(4'd0, 4'd0, 4'd0, 4'd0, 88, 12, 24, 42, 1, 0));
    tbl.push_back(mk(4'd1, 4'd0, 4'd0, 4'd0, 40, 30,  0,  0, 1, 0));
    tbl.push_back(mk(4'd2, 4'd0, 4'd0, 4'd0, 40,  0, 30,  0, 1, 0));
    tbl.push_back(mk(4'd3, 4'd0, 4'd0, 4'd0, 40,  0,  0, 30, 1, 0));
    tbl.push_back(mk(4'd4, 4'd0, 4'd0, 4'd0, 46, 18, 18,  0, 1, 0));
    tbl.push_back(mk(4'd5, 4'd0, 4'd0, 4'd0, 46,  0, 18, 18, 1, 0));
    tbl.push_back(mk(4'd6, 4'd0, 4'd0, 4'd0, 46, 18,  0, 18, 1, 0));
    tbl.push_back(mk(4'd7, 4'd0, 4'd0, 4'd0, 46, 12, 12, 12, 1, 0));
    tbl.push_back(mk(4'd8, 4'd0, 4'd0, 4'd0,  0,  0,  0,  0, 0, 1));
    tbl.push_back(mk(4'd9, 4'd0, 4'd0, 4'd0,  0,  0,  0,  0, 0, 1));
`ifdef CUSTOM_RECIPE_EN
    tbl.push_back(mk(4'd15, 4'd1, 4'd1, 4'd1, 28,  6,  6,  6, 1, 0));
    tbl.push_back(mk(4'd15, 4'd0, 4'd0, 4'd0,  0,  0,  0,  0, 0, 1));
`else
    tbl.push_back(mk(4'd15, 4'd1, 4'd1, 4'd1,  0,  0,  0,  0, 0, 1));
`endif

    repeat (3) @(negedge clk_cnt);
    check("reset.outs", all_outs(), 0);
    check("reset.state", int'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk_cnt);
    check("idle.outs", all_outs(), 0);

    for (int k = 0; k < tbl.size(); k++)
      run_txn(tbl[k], $sformatf("vec%0d_id%0d", k, tbl[k].id));

    rst_mid_seq();
    held_req_seq();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/color_recipe_sequencer.md
Name: color_recipe_sequencer

Overview:
- Upstream controller for the three colorant stepper-motor drivers (red, yellow, blue).
- Accepts a colour request, looks up its recipe and sequences the dispense.
  - Recipe = number of dispense rounds per colorant.
  - Drives per-colorant enables and the carriage move between stations.
- Runs on the slow tick clock clk_cnt; its enables gate the step drivers running on the fast step clock.

Parameters:
- DEPTH, 6, clk_cnt ticks per dispense round.
- MOVE_TICKS, 2, clk_cnt ticks per carriage hop between adjacent stations.

Ports:
- clk_cnt  in  1  slow tick clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  level request; sampled only in IDLE.
- color_id  in  4  recipe index; sampled with req.
- en_r  out  1  red colorant motor enable.
- en_y  out  1  yellow colorant motor enable.
- en_b  out  1  blue colorant motor enable.
- carriage_en  out  1  carriage motor enable.
- carriage_dir  out  1  0 = forward (R->Y->B), 1 = home (B->R).
- station  out  2  0 = R, 1 = Y, 2 = B.
- busy  out  1  high from LOAD through DONE inclusive.
- done  out  1  one-cycle pulse in DONE.
- err  out  1  one-cycle pulse on invalid color_id.

Behaviour:
- Reset (async, any state): state = IDLE; all outputs 0; station = 0; round and tick counters and latched counts cleared.
- Recipe table (r, y, b):
  - 0: (2, 4, 7)
  - 1: (5, 0, 0)
  - 2: (0, 5, 0)
  - 3: (0, 0, 5)
  - 4: (3, 3, 0)
  - 5: (0, 3, 3)
  - 6: (3, 0, 3)
  - 7: (2, 2, 2)
  - 8..15: invalid.
- Counts are 4-bit; counters are sized so no overflow occurs at 15 rounds x DEPTH.
- IDLE:
  - req = 1 with valid id -> LOAD; counts are latched on that edge.
  - req = 1 with invalid id -> err = 1 for exactly one cycle, stay IDLE.
- LOAD (1 cycle): busy = 1, station = 0. Next state is DROP if the R count > 0, else MOVE.
- DROP: en_<station> = 1 for exactly count x DEPTH cycles. Then:
  - station < 2 -> MOVE.
  - station = 2 -> HOME.
- MOVE: carriage_en = 1, dir = 0, for MOVE_TICKS cycles. On exit, station increments. Next state is DROP if the new station's count > 0, else MOVE again; a zero count at station 2 goes to HOME.
- HOME: carriage_en = 1, dir = 1, for 2 x MOVE_TICKS cycles. On exit, station = 0 -> DONE.
- DONE (1 cycle): done = 1, busy = 1 -> IDLE.
- Exclusivity: at most one of en_r, en_y, en_b, carriage_en is high in any cycle.
- req is ignored while busy. A held req re-triggers only after returning to IDLE, which costs at least one IDLE cycle.
- Total busy cycles = 2 + DEPTH x (r + y + b) + 4 x MOVE_TICKS.
- All outputs are registered and decoded from state and counters; no combinational path from req to outputs.
- Reset mid-sequence aborts immediately: enables drop in the same instant; no done pulse.

Optional Feature:
- Macro: CUSTOM_RECIPE_EN.
- Defined:
  - Adds inputs cust_r, cust_y, cust_b (4 bits each).
  - color_id 15 uses these values, latched at request.
  - If all three are 0: err pulse, stay IDLE.
- Undefined:
  - These ports are absent.
  - color_id 15 is invalid (err pulse).

Test Plan:
- Defaults; reset; req = 1, id = 1 -> busy for 40 cycles; en_r high 30 cycles; en_y and en_b never high; two 2-cycle forward moves; 4-cycle home; done pulse once; station ends at 0.
- id = 0 -> busy 88 cycles; en_r 12, en_y 24, en_b 42 cycles, in that order; enables never overlap.
- id = 9 -> err pulse one cycle; busy stays 0; no enables.
- Assert rst during the yellow drop of id = 7 -> all outputs 0 asynchronously; no done. Then req with id = 3 runs a clean 40-cycle sequence.
- req held high through an id = 2 sequence -> after done, one IDLE cycle, then a second sequence starts; req toggling mid-sequence has no effect.
- With CUSTOM_RECIPE_EN:
  - id = 15, cust = (1, 1, 1) -> en_r, en_y, en_b 6 cycles each; busy 28 cycles.
  - cust = (0, 0, 0) -> err pulse.
